// File: rtl/uart_pkg.sv
// Shared definitions for the Fifo write-side arbiter.
// Contents:
//   state_e - 2-bit FSM encoding: IDLE / ISSUE / WAIT / DONE.
package uart_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_ISSUE = 2'd1;
  localparam logic [1:0] ENC_WAIT  = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ISSUE = ENC_ISSUE,
    ST_WAIT  = ENC_WAIT,
    ST_DONE  = ENC_DONE
  } state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Scans the request vector starting one above last_i, wrapping, and returns
// the first requester found.
// Ports:
//   req_i    in  NUM_PORTS  request vector
//   last_i   in  IDX_W      index granted most recently
//   valid_o  out 1          at least one request present
//   winner_o out IDX_W      selected index (0 when valid_o is low)
module rr_priority_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     winner_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = last_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // Wrap by explicit compare so non-power-of-2 port counts never
      // visit an index that does not exist.
      if (idx == IDX_W'(NUM_PORTS - 1)) begin
        idx = '0;
      end else begin
        idx = idx + IDX_W'(1);
      end
      if (req_i[idx] && !valid_o) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the single write port of a Fifo between NUM_PORTS producers.
// Round-robin, one word per grant; drives the Fifo writeReq/writeAck/full
// handshake. All outputs come straight from registers.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   clientReq     per-producer request level, held with data until ack
//   clientData    flattened producer words, port i at [i*DW +: DW]
//   clientAck     one-cycle pulse when port i's word was written
//   busy          high whenever the FSM is not idle
//   fifoFull      Fifo full flag
//   fifoWriteReq  one-cycle write pulse to the Fifo
//   fifoWriteAck  Fifo write acknowledge (low = rejected because full)
//   fifoDataIn    word presented to the Fifo
module fifo_write_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            clientReq,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] clientData,
  output logic [NUM_PORTS-1:0]            clientAck,
  output logic                            busy,
  input  logic                            fifoFull,
  output logic                            fifoWriteReq,
  input  logic                            fifoWriteAck,
  output logic [DATA_WIDTH-1:0]           fifoDataIn
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        winner_q, winner_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]    ack_q, ack_d;
  logic                    wr_req_q, wr_req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_winner;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i    (clientReq),
    .last_i   (last_grant_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      winner_q     <= '0;
      // Reset to the top index so port 0 is first in line.
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      ack_q        <= '0;
      wr_req_q     <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      wr_req_q     <= wr_req_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    wr_req_d     = 1'b0;
    data_d       = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && !fifoFull) begin
          winner_d = pick_winner;
          // Data is captured here only; producer changes afterwards are
          // ignored for this word.
          data_d   = clientData[pick_winner*DATA_WIDTH +: DATA_WIDTH];
          wr_req_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Fifo samples the pulse this cycle; dropping it keeps the request
        // from ever being high two cycles running.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifoWriteAck) begin
          ack_d[winner_q] = 1'b1;
          last_grant_d    = winner_q;
          state_d         = ST_DONE;
        end else begin
          // Rejected (Fifo filled at issue): retry without moving priority.
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // Ack is visible now; skip arbitration so the producer can drop
        // or renew its request before being considered again.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clientAck    = ack_q;
  assign fifoWriteReq = wr_req_q;
  assign fifoDataIn   = data_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int DW = 16;
  localparam int NW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req;
  logic [2*DW-1:0] cdata;
  logic [1:0]      ack;
  logic            busy;
  logic            ffull;
  logic            wreq;
  logic            wack;
  logic [DW-1:0]   fdin;

  logic [2:0]      req3;
  logic [3*DW-1:0] cdata3;
  logic [2:0]      ack3;
  logic            busy3;
  logic            wreq3;
  logic            wack3;
  logic [DW-1:0]   fdin3;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clientReq(req), .clientData(cdata),
    .clientAck(ack), .busy(busy), .fifoFull(ffull),
    .fifoWriteReq(wreq), .fifoWriteAck(wack), .fifoDataIn(fdin)
  );

  fifo_write_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst), .clientReq(req3), .clientData(cdata3),
    .clientAck(ack3), .busy(busy3), .fifoFull(1'b0),
    .fifoWriteReq(wreq3), .fifoWriteAck(wack3), .fifoDataIn(fdin3)
  );

  // Behavioural Fifo (4 entries, full at 3 words). Accepted words are logged.
  int            fifo_cnt = 0;
  logic          force_full;
  logic          rd_en;
  logic [DW-1:0] wr_log[$];

  assign ffull = (fifo_cnt >= 3) || force_full;

  always @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= 0;
      wack     <= 1'b0;
    end else begin
      fifo_cnt <= fifo_cnt + ((wreq && !ffull) ? 1 : 0) - ((rd_en && fifo_cnt > 0) ? 1 : 0);
      wack     <= wreq && !ffull;
      if (wreq && !ffull) wr_log.push_back(fdin);
    end
  end

  // Always-accepting Fifo for the 3-port instance.
  always @(posedge clk) begin
    if (rst) wack3 <= 1'b0;
    else     wack3 <= wreq3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; cdata = '0; req3 = '0; cdata3 = '0;
    rd_en = 1'b0; force_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wr_log.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", ack); end
    checks++; if (wreq !== 1'b0) begin errors++; $display("FAIL reset_wreq got %b want 0", wreq); end
    checks++; if (fdin !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", fdin); end
    checks++; if (busy3 !== 1'b0 || ack3 !== 3'b000) begin errors++; $display("FAIL reset_dut3 got busy=%b ack=%b want 0/000", busy3, ack3); end
    $display("reset done");
  endtask

  task automatic test_single_write();
    do_reset();
    req = 2'b01; cdata = {16'h0000, 16'hA5A5};
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (wreq !== (c == 1)) begin errors++; $display("FAIL single_wreq cycle %0d got %b want %b", c, wreq, (c == 1)); end
      checks++; if (ack !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_ack cycle %0d got %b", c, ack); end
      if (c == 1) begin
        checks++; if (fdin !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h want a5a5", fdin); end
      end
      if (ack[0]) begin req = 2'b00; $display("single: ack port0 cycle %0d", c); end
    end
    req = 2'b00;
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'hA5A5) begin
      errors++; $display("FAIL single_fifo got %0d words want 1 word a5a5", wr_log.size());
    end
  endtask

  task automatic test_contention();
    int got[$];
    logic prev_w = 1'b0;
    do_reset();
    req = 2'b11; cdata = {16'h2222, 16'h1111}; rd_en = 1'b1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      tick();
      checks++; if (wreq && prev_w) begin errors++; $display("FAIL contention_wreq_double at cycle %0d", c); end
      prev_w = wreq;
      if (ack != 2'b00) begin
        got.push_back(ack == 2'b01 ? 0 : (ack == 2'b10 ? 1 : -1));
        $display("contention: ack %b", ack);
      end
    end
    req = 2'b00; rd_en = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL contention_timeout got %0d acks want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] != k % 2) begin errors++; $display("FAIL contention_order ack %0d got port %0d want %0d", k, got[k], k % 2); end
      end
    end
    checks++;
    if (wr_log.size() != 4) begin
      errors++; $display("FAIL contention_fifo_count got %0d want 4", wr_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_log[k] !== ((k % 2) ? 16'h2222 : 16'h1111)) begin
          errors++; $display("FAIL contention_fifo_word %0d got %h want %h", k, wr_log[k], (k % 2) ? 16'h2222 : 16'h1111);
        end
      end
    end
  endtask

  task automatic test_full();
    int n = 0;
    int wcnt = 0;
    int acnt = 0;
    do_reset();
    rd_en = 1'b0;
    req = 2'b01; cdata = {16'h0000, 16'hF000};
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (ack[0]) begin
        n++;
        cdata[15:0] = 16'hF000 + 16'(n);
        if (n == 3) req = 2'b00;
      end
    end
    req = 2'b00;
    checks++; if (n != 3) begin errors++; $display("FAIL full_fill_timeout got %0d acks want 3", n); end
    tick();
    checks++; if (ffull !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", ffull); end
    req = 2'b10; cdata[31:16] = 16'h3333;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (wreq) wcnt++;
    end
    checks++; if (wcnt != 0) begin errors++; $display("FAIL full_no_issue got %0d write pulses want 0", wcnt); end
    rd_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      rd_en = 1'b0;
      if (wreq) wcnt++;
      if (ack[1]) begin acnt++; req = 2'b00; $display("full: ack port1"); end
    end
    checks++; if (wcnt != 1) begin errors++; $display("FAIL full_write_once got %0d pulses want 1", wcnt); end
    checks++; if (acnt != 1) begin errors++; $display("FAIL full_ack_once got %0d acks want 1", acnt); end
    checks++;
    if (wr_log.size() != 4 || wr_log[3] !== 16'h3333) begin
      errors++; $display("FAIL full_fifo_word got %0d words want 4 ending 3333", wr_log.size());
    end
  endtask

  task automatic test_reject();
    int wcnt = 0;
    int acnt = 0;
    bit seen = 0;
    do_reset();
    req = 2'b01; cdata = {16'h0000, 16'h4444};
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (wreq) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL reject_issue_timeout got no write pulse"); end
    wcnt = 1;
    force_full = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 1) force_full = 1'b0;
      if (wreq) wcnt++;
      if (ack != 2'b00) begin
        acnt++;
        req = 2'b00;
        $display("reject: ack %b at cycle %0d", ack, c);
        checks++; if (c < 2) begin errors++; $display("FAIL reject_early_ack got ack at cycle %0d want none before retry", c); end
      end
    end
    force_full = 1'b0;
    checks++; if (wcnt != 2) begin errors++; $display("FAIL reject_retries got %0d pulses want 2", wcnt); end
    checks++; if (acnt != 1) begin errors++; $display("FAIL reject_ack got %0d acks want 1", acnt); end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h4444) begin
      errors++; $display("FAIL reject_fifo got %0d words want exactly one 4444", wr_log.size());
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen = 0;
    int first = -1;
    do_reset();
    req = 2'b10; cdata = {16'h5555, 16'h6666};
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (wreq) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstwait_issue_timeout got no write pulse"); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_log.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwait_busy got %b want 0", busy); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rstwait_ack got %b want 00", ack); end
    checks++; if (wreq !== 1'b0) begin errors++; $display("FAIL rstwait_wreq got %b want 0", wreq); end
    checks++; if (fifo_cnt != 0) begin errors++; $display("FAIL rstwait_fifo got %0d words want 0", fifo_cnt); end
    req = 2'b11;
    for (int c = 0; c < 20 && first < 0; c++) begin
      tick();
      if (ack != 2'b00) begin first = ack[1] ? 1 : 0; $display("rstwait: first ack %b", ack); end
    end
    req = 2'b00;
    checks++; if (first != 0) begin errors++; $display("FAIL rstwait_first got port %0d want 0", first); end
    tick(); tick();
  endtask

  task automatic test_three_ports();
    int got[$];
    int samples[3] = '{0, 0, 0};
    do_reset();
    req3 = 3'b110; cdata3 = {16'hC002, 16'hC001, 16'hC000};
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int p = 0; p < 3; p++) begin
        if (ack3[p]) begin
          samples[p]++;
          if (samples[p] == 1) got.push_back(p);
          req3[p] = 1'b0;
          $display("three: ack port%0d", p);
        end
      end
    end
    req3 = '0;
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL three_count got %0d grants want 2", got.size());
    end else begin
      checks++; if (got[0] != 1) begin errors++; $display("FAIL three_first got port %0d want 1", got[0]); end
      checks++; if (got[1] != 2) begin errors++; $display("FAIL three_second got port %0d want 2", got[1]); end
    end
    checks++;
    if (samples[0] != 0 || samples[1] != 1 || samples[2] != 1) begin
      errors++; $display("FAIL three_pulse_width got %0d/%0d/%0d want 0/1/1", samples[0], samples[1], samples[2]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] words[2][NW];
    int hd[2] = '{0, 0};
    int exp_next = -1;
    logic prev_w = 1'b0;
    logic [DW-1:0] w;
    int p;
    do_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NW; k++) words[i][k] = 16'($urandom);
    for (int c = 0; c < 3000 && (hd[0] < NW || hd[1] < NW); c++) begin
      tick();
      checks++; if (wreq && prev_w) begin errors++; $display("FAIL random_wreq_double at cycle %0d", c); end
      prev_w = wreq;
      if (ack != 2'b00) begin
        checks++;
        if (ack == 2'b11) begin errors++; $display("FAIL random_ack_onehot got %b", ack); end
        p = ack[1] ? 1 : 0;
        if (exp_next >= 0) begin
          checks++;
          if (p != exp_next) begin errors++; $display("FAIL random_fairness got port %0d want %0d", p, exp_next); end
        end
        exp_next = req[1 - p] ? 1 - p : -1;
        checks++;
        if (hd[p] >= NW) begin
          errors++; $display("FAIL random_extra_ack port %0d got ack want none", p);
        end else if (wr_log.size() == 0) begin
          errors++; $display("FAIL random_word port %0d got no Fifo write want %h", p, words[p][hd[p]]);
        end else begin
          w = wr_log.pop_front();
          if (w !== words[p][hd[p]]) begin errors++; $display("FAIL random_word port %0d got %h want %h", p, w, words[p][hd[p]]); end
          $display("random: port%0d word %h", p, w);
          hd[p]++;
        end
        req[p] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && hd[i] < NW && $urandom_range(1, 0) == 1) begin
          req[i] = 1'b1;
          cdata[i*DW +: DW] = words[i][hd[i]];
        end
      end
      rd_en      = ($urandom_range(3, 0) == 0);
      force_full = ($urandom_range(9, 0) == 0);
    end
    req = 2'b00; rd_en = 1'b0; force_full = 1'b0;
    checks++; if (hd[0] != NW || hd[1] != NW) begin errors++; $display("FAIL random_timeout got %0d/%0d words want %0d/%0d", hd[0], hd[1], NW, NW); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL random_leftover got %0d unacked writes want 0", wr_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_full();
    test_reject();
    test_reset_in_wait();
    test_three_ports();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
